// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads the combinational instruction
// memory and buffers fetched words for decode behind a valid/ready handshake.
module fetch_controller #(
  parameter int unsigned MEM_BYTES  = 512,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] MemAddress,
  input  logic [31:0] MemInstruction,
  output logic        InstValid,
  input  logic        InstReady,
  output logic [31:0] InstOut,
  output logic [31:0] InstPC,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Halt,
  output logic        Fault,
  output logic [31:0] FaultPC,
  output logic [31:0] FetchCount
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t            state;
  logic [31:0]       pc;
  logic [31:0]       buf_inst [FIFO_DEPTH];
  logic [31:0]       buf_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              pop_c;
  logic              full_c;
  logic              bad_pc_c;
  logic              try_fetch_c;
  logic              push_c;
  logic [PTR_W-1:0]  rd_next_c;
  logic [CNT_W-1:0]  left_c;
  logic              next_valid_c;
  logic [31:0]       head_inst_c;
  logic [31:0]       head_pc_c;

  assign MemAddress = pc;

  // Fetch/pop decisions and the head entry that will be visible after this edge.
  always_comb begin
    pop_c        = InstValid & InstReady;
    full_c       = (count == DEPTH_C);
    bad_pc_c     = (pc[1:0] != 2'b00) || (pc > LAST_PC);
    try_fetch_c  = (state != S_FAULT) && !Halt && !Redirect && (!full_c || pop_c);
    push_c       = try_fetch_c && !bad_pc_c;
    rd_next_c    = rd_ptr + PTR_W'(pop_c);
    left_c       = count - CNT_W'(pop_c);
    next_valid_c = (left_c != '0) || push_c;
    head_inst_c  = MemInstruction;
    head_pc_c    = pc;
    // With entries left after the pop the new head is already stored; otherwise
    // it is the word being fetched this cycle (if any).
    if (left_c != '0) begin
      head_inst_c = buf_inst[rd_next_c];
      head_pc_c   = buf_pc[rd_next_c];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_RUN;
      pc         <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      InstValid  <= 1'b0;
      InstOut    <= '0;
      InstPC     <= '0;
      Fault      <= 1'b0;
      FaultPC    <= '0;
      FetchCount <= '0;
    end else begin
      FetchCount <= FetchCount + 32'(pop_c);
      if (Redirect) begin
        // Flush and restart; InstOut/InstPC keep their stale contents.
        state     <= S_RUN;
        pc        <= RedirectPC;
        Fault     <= 1'b0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        InstValid <= 1'b0;
      end else begin
        rd_ptr    <= rd_next_c;
        count     <= left_c + CNT_W'(push_c);
        InstValid <= next_valid_c;
        if (next_valid_c) begin
          InstOut <= head_inst_c;
          InstPC  <= head_pc_c;
        end
        if (push_c) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          pc     <= pc + 32'd4;
        end
        case (state)
          S_RUN, S_HALTED: begin
            if (Halt) begin
              state <= S_HALTED;
            end else if (try_fetch_c && bad_pc_c) begin
              state   <= S_FAULT;
              Fault   <= 1'b1;
              FaultPC <= pc;
            end else begin
              state <= S_RUN;
            end
          end
          default: state <= S_FAULT;
        endcase
      end
    end
  end

  // Buffer storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge Clk) begin
    if (push_c) begin
      buf_inst[wr_ptr] <= MemInstruction;
      buf_pc[wr_ptr]   <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: vector table plus reset-state and
// asynchronous-reset sequences.
module tb_fetch_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] MemAddress;
  logic [31:0] MemInstruction;
  logic        InstValid;
  logic        InstReady;
  logic [31:0] InstOut;
  logic [31:0] InstPC;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Halt;
  logic        Fault;
  logic [31:0] FaultPC;
  logic [31:0] FetchCount;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_controller #(
    .MEM_BYTES (512),
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .MemAddress    (MemAddress),
    .MemInstruction(MemInstruction),
    .InstValid     (InstValid),
    .InstReady     (InstReady),
    .InstOut       (InstOut),
    .InstPC        (InstPC),
    .Redirect      (Redirect),
    .RedirectPC    (RedirectPC),
    .Halt          (Halt),
    .Fault         (Fault),
    .FaultPC       (FaultPC),
    .FetchCount    (FetchCount)
  );

  always #5 Clk = ~Clk;

  // Memory image: two known words at 0 and 4, address-tagged words elsewhere.
  always_comb begin
    if (MemAddress == 32'h0)      MemInstruction = 32'h1122_3344;
    else if (MemAddress == 32'h4) MemInstruction = 32'h5566_7788;
    else                          MemInstruction = {16'hC0DE, MemAddress[15:0]};
  end

  typedef struct {
    logic        ready;
    logic        redir;
    logic        halt;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_out;
    logic [31:0] e_ipc;
    logic [31:0] e_addr;
    logic        e_fault;
    logic [31:0] e_fpc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic h, input logic [31:0] rpc,
                     input logic v, input logic [31:0] o, input logic [31:0] ip,
                     input logic [31:0] a, input logic f, input logic [31:0] fp,
                     input logic [31:0] c);
    vec_t t;
    t.ready = r; t.redir = rd; t.halt = h; t.rpc = rpc;
    t.e_valid = v; t.e_out = o; t.e_ipc = ip; t.e_addr = a;
    t.e_fault = f; t.e_fpc = fp; t.e_cnt = c;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] o,
                           input logic [31:0] ip, input logic [31:0] a, input logic f,
                           input logic [31:0] fp, input logic [31:0] c);
    check({tag, ".InstValid"},  32'(InstValid), 32'(v));
    check({tag, ".InstOut"},    InstOut, o);
    check({tag, ".InstPC"},     InstPC, ip);
    check({tag, ".MemAddress"}, MemAddress, a);
    check({tag, ".Fault"},      32'(Fault), 32'(f));
    check({tag, ".FaultPC"},    FaultPC, fp);
    check({tag, ".FetchCount"}, FetchCount, c);
  endtask

  initial begin
    bit seen;
    Reset = 1'b1; InstReady = 1'b0; Redirect = 1'b0; RedirectPC = '0; Halt = 1'b0;

    //   rdy rdr hlt rpc        | vld out            ipc        addr       flt fpc        cnt
    // Stall with ready low: two entries (0, 4) buffered, PC parked at 8
    add(0, 0, 0, 32'h0,   1, 32'h1122_3344, 32'h0,   32'h4,   0, 32'h0,   0);
    add(0, 0, 0, 32'h0,   1, 32'h1122_3344, 32'h0,   32'h8,   0, 32'h0,   0);
    add(0, 0, 0, 32'h0,   1, 32'h1122_3344, 32'h0,   32'h8,   0, 32'h0,   0);
    add(0, 0, 0, 32'h0,   1, 32'h1122_3344, 32'h0,   32'h8,   0, 32'h0,   0);
    add(0, 0, 0, 32'h0,   1, 32'h1122_3344, 32'h0,   32'h8,   0, 32'h0,   0);
    // Resume: full FIFO pops and fetches together, no gaps
    add(1, 0, 0, 32'h0,   1, 32'h5566_7788, 32'h4,   32'hC,   0, 32'h0,   1);
    add(1, 0, 0, 32'h0,   1, 32'hC0DE_0008, 32'h8,   32'h10,  0, 32'h0,   2);
    add(1, 0, 0, 32'h0,   1, 32'hC0DE_000C, 32'hC,   32'h14,  0, 32'h0,   3);
    // Redirect to 0x40 with full FIFO and a pop in the same cycle
    add(1, 1, 0, 32'h40,  0, 32'hC0DE_000C, 32'hC,   32'h40,  0, 32'h0,   4);
    add(1, 0, 0, 32'h0,   1, 32'hC0DE_0040, 32'h40,  32'h44,  0, 32'h0,   4);
    add(1, 0, 0, 32'h0,   1, 32'hC0DE_0044, 32'h44,  32'h48,  0, 32'h0,   5);
    // Halt for three cycles, then resume at the frozen PC
    add(1, 0, 1, 32'h0,   0, 32'hC0DE_0044, 32'h44,  32'h48,  0, 32'h0,   6);
    add(1, 0, 1, 32'h0,   0, 32'hC0DE_0044, 32'h44,  32'h48,  0, 32'h0,   6);
    add(1, 0, 1, 32'h0,   0, 32'hC0DE_0044, 32'h44,  32'h48,  0, 32'h0,   6);
    add(1, 0, 0, 32'h0,   1, 32'hC0DE_0048, 32'h48,  32'h4C,  0, 32'h0,   6);
    add(1, 0, 0, 32'h0,   1, 32'hC0DE_004C, 32'h4C,  32'h50,  0, 32'h0,   7);
    // Misaligned redirect faults on the next fetch attempt
    add(1, 1, 0, 32'h22,  0, 32'hC0DE_004C, 32'h4C,  32'h22,  0, 32'h0,   8);
    add(1, 0, 0, 32'h0,   0, 32'hC0DE_004C, 32'h4C,  32'h22,  1, 32'h22,  8);
    add(1, 0, 0, 32'h0,   0, 32'hC0DE_004C, 32'h4C,  32'h22,  1, 32'h22,  8);
    // Redirect near the top of memory and run off the end
    add(1, 1, 0, 32'h1F4, 0, 32'hC0DE_004C, 32'h4C,  32'h1F4, 0, 32'h22,  8);
    add(1, 0, 0, 32'h0,   1, 32'hC0DE_01F4, 32'h1F4, 32'h1F8, 0, 32'h22,  8);
    add(1, 0, 0, 32'h0,   1, 32'hC0DE_01F8, 32'h1F8, 32'h1FC, 0, 32'h22,  9);
    add(0, 0, 0, 32'h0,   1, 32'hC0DE_01F8, 32'h1F8, 32'h200, 0, 32'h22,  9);
    add(1, 0, 0, 32'h0,   1, 32'hC0DE_01FC, 32'h1FC, 32'h200, 1, 32'h200, 10);
    add(1, 0, 0, 32'h0,   0, 32'hC0DE_01FC, 32'h1FC, 32'h200, 1, 32'h200, 11);
    add(1, 0, 0, 32'h0,   0, 32'hC0DE_01FC, 32'h1FC, 32'h200, 1, 32'h200, 11);
    // Redirect clears the fault
    add(1, 1, 0, 32'h0,   0, 32'hC0DE_01FC, 32'h1FC, 32'h0,   0, 32'h200, 11);
    add(1, 0, 0, 32'h0,   1, 32'h1122_3344, 32'h0,   32'h4,   0, 32'h200, 11);
    // Redirect with Halt held: halted the following cycle, then resumes
    add(1, 1, 1, 32'h100, 0, 32'h1122_3344, 32'h0,   32'h100, 0, 32'h200, 12);
    add(1, 0, 1, 32'h0,   0, 32'h1122_3344, 32'h0,   32'h100, 0, 32'h200, 12);
    add(1, 0, 0, 32'h0,   1, 32'hC0DE_0100, 32'h100, 32'h104, 0, 32'h200, 12);

    #12 Reset = 1'b0;
    #1 check_all("reset", 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0);

    foreach (vecs[i]) begin
      InstReady  = vecs[i].ready;
      Redirect   = vecs[i].redir;
      Halt       = vecs[i].halt;
      RedirectPC = vecs[i].rpc;
      @(posedge Clk);
      #1;
      check_all($sformatf("vec%0d", i + 1), vecs[i].e_valid, vecs[i].e_out, vecs[i].e_ipc,
                vecs[i].e_addr, vecs[i].e_fault, vecs[i].e_fpc, vecs[i].e_cnt);
    end

    // Fill the FIFO, then assert reset away from any clock edge
    InstReady = 1'b0; Redirect = 1'b0; Halt = 1'b0; RedirectPC = '0;
    @(posedge Clk);
    #1 check("prefill.InstPC", InstPC, 32'h100);
    #3 Reset = 1'b1;
    #1 check_all("async_reset", 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0);
    #2 Reset = 1'b0;

    // First word after reset, bounded wait
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(posedge Clk);
      #1;
      if (InstValid) seen = 1'b1;
    end
    check("post_reset.seen", 32'(seen), 32'h1);
    check("post_reset.InstOut", InstOut, 32'h1122_3344);
    check("post_reset.InstPC", InstPC, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the byte-addressed, combinational-read instruction memory (512 bytes, big-endian 4-byte words).
- Owns the program counter and drives the memory address.
- Captures each returned word into a small FIFO and hands it to decode over a valid/ready handshake.
- Handles redirects (branch/jump), halt, and fetch faults (misaligned or out-of-range PC).

Parameters:
- MEM_BYTES, 512, instruction memory size in bytes; legal fetch PCs are 0..MEM_BYTES-4.
- RESET_PC, 32'h0000_0000, PC value after reset.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, ≥2.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MemAddress  out  32  byte address to instruction memory; equals PC combinationally.
- MemInstruction  in  32  word returned by memory for MemAddress, same cycle.
- InstValid  out  1  FIFO head valid.
- InstReady  in  1  decode accepts head this cycle.
- InstOut  out  32  head instruction.
- InstPC  out  32  PC of head instruction.
- Redirect  in  1  load RedirectPC, flush FIFO.
- RedirectPC  in  32  new PC.
- Halt  in  1  level; suppresses new fetches.
- Fault  out  1  fetch fault pending.
- FaultPC  out  32  PC that faulted.
- FetchCount  out  32  number of instructions accepted by decode.

Behaviour:
- Interface: one clock, Clk; asynchronous active-high reset, Reset.
- Reset values:
  - PC = RESET_PC; FIFO empty.
  - InstValid = 0; InstOut and InstPC = 0.
  - Fault = 0; FaultPC = 0; FetchCount = 0.
  - State = RUN; MemAddress = RESET_PC.
- States:
  - RUN → HALTED when Halt=1.
  - HALTED → RUN when Halt=0.
  - RUN → FAULT on a bad PC.
  - FAULT → RUN only on Redirect.
  - Redirect from any state → RUN. If Halt is still high after the Redirect, HALTED applies next cycle.
- Pop: occurs when InstValid & InstReady. FetchCount increments (wraps at 2^32).
- Fetch in RUN:
  - Condition: Halt=0, Redirect=0, and (FIFO not full or a pop this cycle).
  - Bad PC check: PC[1:0]≠0 or PC > MEM_BYTES-4.
  - If PC is not bad: push {MemInstruction, PC} and PC += 4.
  - If PC is bad: no push, PC held, Fault ← 1, FaultPC ← PC, state ← FAULT.
- Latency: word fetched at edge N appears on InstValid/InstOut after edge N; decode sees it in cycle N+1. Back-to-back throughput is 1 word/cycle with continuous InstReady.
- Full FIFO with simultaneous pop and fetch: both occur; occupancy unchanged.
- Halt:
  - No fetches; PC frozen.
  - FIFO continues draining.
  - Deasserting Halt resumes fetch the same cycle it is low.
- Redirect (highest priority):
  - FIFO flushed at the edge.
  - PC ← RedirectPC; Fault ← 0; no push that cycle.
  - A pop in the same cycle still counts (FetchCount increments).
  - First word from RedirectPC is valid two cycles after Redirect assertion (fetch in cycle +1, visible in +2).
- FAULT:
  - No fetches.
  - Remaining FIFO entries still drain.
  - Fault stays high until Redirect.
- Reset mid-operation: immediate asynchronous return to reset values; in-flight entries are lost.
- Arithmetic:
  - PC increment is 32-bit unsigned.
  - An increment past MEM_BYTES-4 produces a bad PC, which faults on the next fetch attempt.
- InstOut/InstPC hold their last head value when InstValid=0; decode must not use them in that case.

Test Plan:
- Straight-line run, InstReady=1, memory words 0x11223344 at 0 and 0x55667788 at 4 → InstValid high from cycle 1; InstOut/InstPC = 0x11223344/0, then 0x55667788/4; FetchCount increments each cycle.
- InstReady=0 for 5 cycles → exactly FIFO_DEPTH=2 entries (PC 0, 4) buffered; PC stalls at 8; MemAddress=8; then InstReady=1 resumes the order 0, 4, 8 with no gaps.
- Redirect to 0x40 while FIFO holds 2 entries and InstReady=1 → FIFO empty next cycle; FetchCount +1; InstPC=0x40 valid 2 cycles after Redirect.
- Straight-line fetch to PC=508 with MEM_BYTES=512 → word at 508 delivered; at PC 512, Fault=1 and FaultPC=512; InstValid drops after the drain; Redirect to 0 clears Fault.
- Redirect to 0x22 (misaligned) → next cycle Fault=1, FaultPC=0x22, no push.
- Halt asserted for 3 cycles mid-stream → PC frozen; FIFO drains to empty; release resumes at the frozen PC. Reset asserted asynchronously mid-stream → outputs return to reset values immediately, without waiting for a Clk edge.
